// File: rtl/dice_roller_bcd.sv
// -----------------------------------------------------------------------------
// dice_roller_bcd
//   Electronic dice. Holding a die-select button spins a BCD counter that
//   counts down from the die's side count and wraps. Releasing the button
//   freezes the counter, which becomes the roll result. Each roll either
//   replaces or is added to a saturating BCD running total, and a saturating
//   binary roll counter is kept alongside it.
//
// Parameters
//   DIGITS      : number of BCD digits in sum (3..8)
//   SYNC_STAGES : synchroniser depth applied to btn (1..3)
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   btn[6:0]  : asynchronous die select, bit0..6 = d4,d6,d8,d10,d12,d20,d100
//   accum_en  : 1 = add each roll to sum, 0 = each roll replaces sum
//   clr_sum   : synchronous clear of sum and roll_cnt
//   result    : last roll as two BCD digits {tens,ones}; 100 reads as 8'h00
//   sum       : BCD running total, saturates at all nines
//   roll_cnt  : binary count of completed rolls, saturates at 255
//   roll_done : one-cycle pulse in the cycle result/sum show a new roll
//   spinning  : high while a roll is in progress
// -----------------------------------------------------------------------------
module dice_roller_bcd #(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            btn,
  input  logic                  accum_en,
  input  logic                  clr_sum,
  output logic [7:0]            result,
  output logic [4*DIGITS-1:0]   sum,
  output logic [7:0]            roll_cnt,
  output logic                  roll_done,
  output logic                  spinning
);

  localparam int SW = 4 * DIGITS;
  localparam logic [SW-1:0] SUM_MAX = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, SPIN, DONE} state_t;

  // Side count of each die in BCD; the d100 reads 8'h00 in two digits.
  function automatic logic [7:0] sides_bcd(input logic [2:0] s);
    case (s)
      3'd0:    return 8'h04;
      3'd1:    return 8'h06;
      3'd2:    return 8'h08;
      3'd3:    return 8'h10;
      3'd4:    return 8'h12;
      3'd5:    return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

  // Two-digit BCD decrement; 00 (the d100 "100") steps down to 99.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [3:0] tens;
    if (v[3:0] != 4'h0) return {v[7:4], v[3:0] - 4'd1};
    tens = (v[7:4] == 4'h0) ? 4'h9 : v[7:4] - 4'd1;
    return {tens, 4'h9};
  endfunction

  // ---------------------------------------------------------------------------
  // Button synchroniser
  // ---------------------------------------------------------------------------
  logic [6:0] sync_q [SYNC_STAGES];
  logic [6:0] btn_s;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values and the chain shifts by exactly one stage.
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= btn;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t        state, state_d;
  logic [2:0]    sel, sel_d;
  logic [7:0]    cnt, cnt_d;
  logic [7:0]    result_d;
  logic [SW-1:0] sum_d;
  logic [7:0]    roll_cnt_d;
  logic          roll_done_d;
  logic          spinning_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 3'd0;
      cnt       <= 8'h01;
      result    <= 8'h01;
      sum       <= '0;
      roll_cnt  <= 8'd0;
      roll_done <= 1'b0;
      spinning  <= 1'b0;
    end else begin
      state     <= state_d;
      sel       <= sel_d;
      cnt       <= cnt_d;
      result    <= result_d;
      sum       <= sum_d;
      roll_cnt  <= roll_cnt_d;
      roll_done <= roll_done_d;
      spinning  <= spinning_d;
    end
  end

  // A roll completes on the edge where the selected button reads released.
  logic roll_fire;
  assign roll_fire = (state == SPIN) && !btn_s[sel];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: a default before any branching keeps this block free of latches.
    state_d = state;
    case (state)
      IDLE:    if (btn_s != 7'd0) state_d = SPIN;
      SPIN:    if (roll_fire)     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  logic [2:0]    sel_lo;
  logic [SW-1:0] value_bcd;
  logic [SW-1:0] sum_base;
  logic [SW-1:0] add_res;
  logic [4:0]    dsum;
  logic          carry;
  logic [7:0]    cnt_base;

  always_comb begin
    // Lowest set button wins when several are pressed together.
    sel_lo = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (btn_s[i]) sel_lo = 3'(i);
    end

    // Roll value widened to the sum width; 8'h00 stands for 100.
    value_bcd = '0;
    value_bcd[11:0] = (cnt == 8'h00) ? 12'h100 : {4'h0, cnt};

    // Clear acts first so a coincident roll lands on a zero total.
    sum_base = clr_sum ? '0 : sum;
    cnt_base = clr_sum ? 8'd0 : roll_cnt;

    // Digit-serial BCD add with decimal adjust.
    carry   = 1'b0;
    dsum    = 5'd0;
    add_res = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dsum = {1'b0, sum_base[4*i +: 4]} + {1'b0, value_bcd[4*i +: 4]} + {4'd0, carry};
      if (dsum > 5'd9) begin
        dsum  = dsum + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      add_res[4*i +: 4] = dsum[3:0];
    end

    sel_d       = sel;
    cnt_d       = cnt;
    result_d    = result;
    sum_d       = sum_base;
    roll_cnt_d  = cnt_base;
    roll_done_d = 1'b0;

    case (state)
      IDLE: begin
        if (btn_s != 7'd0) begin
          sel_d = sel_lo;
          cnt_d = sides_bcd(sel_lo);
        end
      end
      SPIN: begin
        if (btn_s[sel]) begin
          cnt_d = (cnt == 8'h01) ? sides_bcd(sel) : bcd_dec(cnt);
        end else begin
          result_d    = cnt;
          roll_done_d = 1'b1;
          sum_d       = !accum_en ? value_bcd : (carry ? SUM_MAX : add_res);
          roll_cnt_d  = (cnt_base == 8'd255) ? 8'd255 : cnt_base + 8'd1;
        end
      end
      default: ;
    endcase

    spinning_d = (state_d == SPIN);
  end

endmodule
